// File: rtl/dcache_responder.sv
// Direct-mapped, write-back, write-allocate data cache with one-word frames.
// Services datapath loads/stores over a dwait handshake and writes back dirty frames on halt.
module dcache_responder #(
    parameter int SETS  = 16,
    parameter int IDX_W = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        halt,
    input  logic        dmemREN,
    input  logic        dmemWEN,
    input  logic [31:0] dmemaddr,
    input  logic [31:0] dmemstore,
    output logic        dhit,
    output logic [31:0] dmemload,
    output logic        flushed,
    output logic        mem_dREN,
    output logic        mem_dWEN,
    output logic [31:0] mem_daddr,
    output logic [31:0] mem_dstore,
    input  logic        mem_dwait,
    input  logic [31:0] mem_dload
);
    localparam int TAG_W = 32 - IDX_W - 2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

    typedef enum logic [2:0] {IDLE, WB, ALLOC, FLUSH, FLUSH_WB, HALTED} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [SETS-1:0]  valid_q, valid_d;
    logic [SETS-1:0]  dirty_q, dirty_d;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [TAG_W-1:0] tag_d  [SETS];
    logic [31:0]      data_q [SETS];
    logic [31:0]      data_d [SETS];

    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;
    logic             req_any;
    logic             req_hit;

    assign req_idx = dmemaddr[IDX_W+1:2];
    assign req_tag = dmemaddr[31:IDX_W+2];
    assign req_any = dmemREN | dmemWEN;
    assign req_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

    // The datapath holds its request through WB/ALLOC, so the request index addresses the victim.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        dirty_d    = dirty_q;
        tag_d      = tag_q;
        data_d     = data_q;
        dhit       = 1'b0;
        dmemload   = '0;
        flushed    = 1'b0;
        mem_dREN   = 1'b0;
        mem_dWEN   = 1'b0;
        mem_daddr  = '0;
        mem_dstore = '0;

        case (state_q)
            IDLE: begin
                if (halt) begin
                    state_d = FLUSH;
                end else if (req_any) begin
                    if (req_hit) begin
                        dhit = 1'b1;
                        if (dmemWEN) begin
                            data_d[req_idx]  = dmemstore;
                            dirty_d[req_idx] = 1'b1;
                        end else begin
                            dmemload = data_q[req_idx];
                        end
                    end else if (valid_q[req_idx] && dirty_q[req_idx]) begin
                        state_d = WB;
                    end else begin
                        state_d = ALLOC;
                    end
                end
            end
            WB: begin
                mem_dWEN   = 1'b1;
                mem_daddr  = {tag_q[req_idx], req_idx, 2'b00};
                mem_dstore = data_q[req_idx];
                if (!mem_dwait) begin
                    dirty_d[req_idx] = 1'b0;
                    state_d          = ALLOC;
                end
            end
            ALLOC: begin
                mem_dREN  = 1'b1;
                mem_daddr = {dmemaddr[31:2], 2'b00};
                if (!mem_dwait) begin
                    data_d[req_idx]  = mem_dload;
                    tag_d[req_idx]   = req_tag;
                    valid_d[req_idx] = 1'b1;
                    dirty_d[req_idx] = 1'b0;
                    state_d          = IDLE;
                end
            end
            // Terminal check comes before the increment so the counter never wraps.
            FLUSH: begin
                if (valid_q[cnt_q] && dirty_q[cnt_q]) begin
                    state_d = FLUSH_WB;
                end else if (cnt_q == LAST_IDX) begin
                    state_d = HALTED;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FLUSH_WB: begin
                mem_dWEN   = 1'b1;
                mem_daddr  = {tag_q[cnt_q], cnt_q, 2'b00};
                mem_dstore = data_q[cnt_q];
                if (!mem_dwait) begin
                    dirty_d[cnt_q] = 1'b0;
                    if (cnt_q == LAST_IDX) begin
                        state_d = HALTED;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = FLUSH;
                    end
                end
            end
            HALTED: begin
                flushed = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= '0;
            dirty_q <= '0;
            for (int i = 0; i < SETS; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            tag_q   <= tag_d;
        end
    end

    // Data words carry no reset; a frame's contents only matter once its valid bit is set.
    always_ff @(posedge CLK) begin
        data_q <= data_d;
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Self-checking bench for dcache_responder: directed scenarios plus randomized traffic
// checked against an architectural memory model and a frame-ownership model.
module tb_dcache_responder;
    localparam int SETS  = 16;
    localparam int IDX_W = 4;

    logic        CLK;
    logic        RST;
    logic        halt;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] dmemaddr;
    logic [31:0] dmemstore;
    logic        dhit;
    logic [31:0] dmemload;
    logic        flushed;
    logic        mem_dREN;
    logic        mem_dWEN;
    logic [31:0] mem_daddr;
    logic [31:0] mem_dstore;
    logic        mem_dwait;
    logic [31:0] mem_dload;

    dcache_responder #(.SETS(SETS), .IDX_W(IDX_W)) dut (
        .CLK(CLK), .RST(RST), .halt(halt),
        .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
        .dhit(dhit), .dmemload(dmemload), .flushed(flushed),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_daddr(mem_daddr),
        .mem_dstore(mem_dstore), .mem_dwait(mem_dwait), .mem_dload(mem_dload)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        int          w;
    } xfer_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem  [logic [31:0]];
    logic [31:0] arch [logic [31:0]];
    bit          mValid [SETS];
    bit          mDirty [SETS];
    logic [29:0] mLine  [SETS];

    xfer_t       expQ[$];
    int          nDone;
    int          stallCnt;
    bit          commitPending;
    bit          commitWr;
    logic [31:0] commitA;
    logic [31:0] commitD;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0000;
    endfunction

    function automatic logic [31:0] archRead(input logic [31:0] a);
        if (arch.exists(a)) return arch[a];
        return memRead(a);
    endfunction

    function automatic int pickWait(input int sel);
        if (sel >= 0) return sel;
        return int'($urandom_range(0, 3));
    endfunction

    task automatic clearModel();
        arch.delete();
        for (int i = 0; i < SETS; i++) begin
            mValid[i] = 1'b0;
            mDirty[i] = 1'b0;
            mLine[i]  = '0;
        end
    endtask

    // Called at the negedge: checks any memory request against the expected transfer list and answers it.
    task automatic serviceMem();
        commitPending = 1'b0;
        if (mem_dREN || mem_dWEN) begin
            checkOutput("one_req", 32'(mem_dREN & mem_dWEN), 32'd0);
            if (nDone >= expQ.size()) begin
                checkOutput("xfer_count", 32'(nDone + 1), 32'(expQ.size()));
                mem_dwait = 1'b1;
            end else begin
                checkOutput("xfer_wen", 32'(mem_dWEN), 32'(expQ[nDone].wr));
                checkOutput("xfer_addr", mem_daddr, expQ[nDone].a);
                if (expQ[nDone].wr) checkOutput("xfer_data", mem_dstore, expQ[nDone].d);
                if (stallCnt < expQ[nDone].w) begin
                    mem_dwait = 1'b1;
                    stallCnt++;
                end else begin
                    mem_dwait     = 1'b0;
                    mem_dload     = memRead(mem_daddr);
                    commitPending = 1'b1;
                    commitWr      = mem_dWEN;
                    commitA       = mem_daddr;
                    commitD       = mem_dstore;
                end
            end
        end else begin
            mem_dwait = 1'b1;
            mem_dload = $urandom;
        end
    endtask

    task automatic finishCycle();
        @(posedge CLK);
        #1;
        if (commitPending) begin
            if (commitWr) mem[commitA] = commitD;
            nDone++;
            stallCnt      = 0;
            commitPending = 1'b0;
        end
    endtask

    task automatic applyReset();
        RST     = 1'b1;
        halt    = 1'b0;
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        mem_dwait = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        clearModel();
    endtask

    task automatic checkResetOutputs();
        @(negedge CLK);
        checkOutput("rst_dhit", 32'(dhit), 32'd0);
        checkOutput("rst_dmemload", dmemload, 32'd0);
        checkOutput("rst_flushed", 32'(flushed), 32'd0);
        checkOutput("rst_mem_dREN", 32'(mem_dREN), 32'd0);
        checkOutput("rst_mem_dWEN", 32'(mem_dWEN), 32'd0);
        checkOutput("rst_mem_daddr", mem_daddr, 32'd0);
        checkOutput("rst_mem_dstore", mem_dstore, 32'd0);
        @(posedge CLK);
        #1;
    endtask

    task automatic idleCycle();
        @(negedge CLK);
        checkOutput("idle_dhit", 32'(dhit), 32'd0);
        checkOutput("idle_mem_req", 32'(mem_dREN | mem_dWEN), 32'd0);
        @(posedge CLK);
        #1;
    endtask

    // One datapath access: predicts hit/miss, the memory transfers and the hit cycle from the model.
    task automatic applyStimulus(input bit wr, input bit both, input logic [31:0] addr,
                                 input logic [31:0] data, input int waitSel);
        logic [31:0]      a;
        logic [IDX_W-1:0] ix;
        bit               hit;
        int               expCycle;
        int               cyc;
        bit               done;
        a   = addr & ~32'h3;
        ix  = a[IDX_W+1:2];
        hit = mValid[ix] && (mLine[ix] == a[31:2]);
        expQ.delete();
        nDone    = 0;
        stallCnt = 0;
        expCycle = 0;
        if (!hit) begin
            if (mValid[ix] && mDirty[ix])
                expQ.push_back('{wr: 1'b1, a: {mLine[ix], 2'b00}, d: archRead({mLine[ix], 2'b00}), w: pickWait(waitSel)});
            expQ.push_back('{wr: 1'b0, a: a, d: 32'h0, w: pickWait(waitSel)});
            expCycle = 1;
            foreach (expQ[i]) expCycle += expQ[i].w + 1;
        end
        dmemaddr  = addr;
        dmemstore = data;
        dmemWEN   = wr;
        dmemREN   = !wr || both;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 100) begin
            @(negedge CLK);
            if (dhit) begin
                checkOutput("hit_cycle", 32'(cyc), 32'(expCycle));
                checkOutput("xfers_at_hit", 32'(nDone), 32'(expQ.size()));
                if (!wr) checkOutput("dmemload", dmemload, archRead(a));
                done = 1'b1;
            end
            serviceMem();
            finishCycle();
            cyc++;
        end
        checkOutput("access_done", 32'(done), 32'd1);
        dmemREN = 1'b0;
        dmemWEN = 1'b0;
        if (done) begin
            if (wr) arch[a] = data;
            mDirty[ix] = wr ? 1'b1 : (hit ? mDirty[ix] : 1'b0);
            mValid[ix] = 1'b1;
            mLine[ix]  = a[31:2];
        end
    endtask

    // Halt: every dirty frame is written back in index order, then flushed rises and sticks.
    task automatic applyFlush();
        int expCycle;
        int cyc;
        bit done;
        expQ.delete();
        nDone    = 0;
        stallCnt = 0;
        expCycle = 1;
        for (int i = 0; i < SETS; i++) begin
            if (mValid[i] && mDirty[i]) begin
                expQ.push_back('{wr: 1'b1, a: {mLine[i], 2'b00}, d: archRead({mLine[i], 2'b00}), w: pickWait(-1)});
                expCycle += 1 + expQ[expQ.size()-1].w + 1;
            end else begin
                expCycle += 1;
            end
        end
        halt = 1'b1;
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 300) begin
            @(negedge CLK);
            checkOutput("flush_dhit", 32'(dhit), 32'd0);
            if (flushed) begin
                checkOutput("flush_cycle", 32'(cyc), 32'(expCycle));
                checkOutput("flush_xfers", 32'(nDone), 32'(expQ.size()));
                done = 1'b1;
            end
            serviceMem();
            finishCycle();
            cyc++;
        end
        checkOutput("flush_done", 32'(done), 32'd1);
        for (int i = 0; i < SETS; i++) mDirty[i] = 1'b0;
        halt     = 1'b0;
        dmemREN  = 1'b1;
        dmemaddr = {mLine[0], 2'b00};
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            checkOutput("halted_dhit", 32'(dhit), 32'd0);
            checkOutput("halted_flushed", 32'(flushed), 32'd1);
            checkOutput("halted_mem_req", 32'(mem_dREN | mem_dWEN), 32'd0);
            @(posedge CLK);
            #1;
        end
        dmemREN = 1'b0;
    endtask

    task automatic randomPhase(input int count);
        logic [25:0] tg;
        logic [IDX_W-1:0] ixv;
        logic [1:0]  lo;
        bit          wr;
        bit          both;
        for (int n = 0; n < count; n++) begin
            tg   = ($urandom_range(0, 3) == 3) ? 26'h3FF_FFFF : 26'($urandom_range(0, 2));
            ixv  = IDX_W'($urandom_range(0, SETS - 1));
            lo   = 2'($urandom_range(0, 3));
            wr   = 1'($urandom_range(0, 1));
            both = wr && ($urandom_range(0, 1) == 1);
            applyStimulus(wr, both, {tg, ixv, lo}, $urandom, -1);
            if ($urandom_range(0, 3) == 0) idleCycle();
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST = 1'b1; halt = 1'b0; dmemREN = 1'b0; dmemWEN = 1'b0;
        dmemaddr = '0; dmemstore = '0; mem_dwait = 1'b1; mem_dload = '0;
        commitPending = 1'b0; commitWr = 1'b0; commitA = '0; commitD = '0;
        nDone = 0; stallCnt = 0;

        applyReset();
        checkResetOutputs();

        mem[32'h100] = 32'hDEADBEEF;
        applyStimulus(1'b0, 1'b0, 32'h100, 32'h0, 2);
        applyStimulus(1'b0, 1'b0, 32'h100, 32'h0, -1);
        applyStimulus(1'b1, 1'b0, 32'h104, 32'h1111_1111, -1);
        applyStimulus(1'b0, 1'b0, 32'h144, 32'h0, -1);
        applyStimulus(1'b0, 1'b0, 32'h200, 32'h0, -1);
        applyStimulus(1'b0, 1'b0, 32'h240, 32'h0, -1);
        applyStimulus(1'b0, 1'b0, 32'h008, 32'h0, -1);
        applyStimulus(1'b1, 1'b1, 32'h008, 32'h5, -1);
        applyStimulus(1'b0, 1'b0, 32'h008, 32'h0, -1);

        randomPhase(300);

        applyReset();
        dmemaddr = 32'h020;
        dmemREN  = 1'b1;
        @(posedge CLK);
        #1;
        @(negedge CLK);
        checkOutput("alloc_req", 32'(mem_dREN), 32'd1);
        checkOutput("alloc_addr", mem_daddr, 32'h020);
        mem_dwait = 1'b1;
        @(posedge CLK);
        #1;
        RST     = 1'b1;
        dmemREN = 1'b0;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        clearModel();
        checkResetOutputs();
        applyStimulus(1'b0, 1'b0, 32'h020, 32'h0, -1);

        applyStimulus(1'b1, 1'b0, 32'h000, 32'hA000_0000, -1);
        applyStimulus(1'b1, 1'b0, 32'h00C, 32'hA000_000C, -1);
        applyStimulus(1'b1, 1'b0, 32'h03C, 32'hA000_003C, -1);
        applyFlush();
        checkOutput("flushed_mem_000", memRead(32'h000), 32'hA000_0000);
        checkOutput("flushed_mem_03C", memRead(32'h03C), 32'hA000_003C);

        applyReset();
        randomPhase(150);
        applyFlush();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
